load_count_reg: RTL and testbench

Parametrised loadable up/down counter register with a programmable modulus, wrap or saturate mode, registered carry and borrow pulses, a sticky overflow flag, and a self-timed run mode that counts to the modulus and signals completion. It is the next generation of the 8-bit init/increment/load counter register used for pointer and loop-count registers in the datapath. Controller FSMs drive it either per cycle through `inc`/`dec` or once through `start`/`done`.

---
 rtl/count_pkg.sv | 35 +++
 rtl/count_step.sv | 51 +++++
 rtl/load_count_reg.sv | 124 ++++++++++++
 tb/tb_load_count_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types for the loadable counter register: run-FSM states and
// command decode with its fixed priority.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  // Non-reset commands, listed highest to lowest priority.
  typedef enum logic [2:0] {
    CMD_CLR  = 3'd0,
    CMD_LD   = 3'd1,
    CMD_RUN  = 3'd2,
    CMD_STEP = 3'd3,
    CMD_HOLD = 3'd4
  } cmd_t;

  // rst is handled in the register process and outranks everything below.
  function automatic cmd_t decode_cmd(input logic clr, input logic ld,
                                      input logic running, input logic inc,
                                      input logic dec);
    if (clr)
      return CMD_CLR;
    if (ld)
      return CMD_LD;
    if (running)
      return CMD_RUN;
    if (inc ^ dec)
      return CMD_STEP;
    return CMD_HOLD;
  endfunction

endpackage

// File: rtl/count_step.sv
// Combinational next-value and boundary logic for one up/down step.
// Ports: q/limit current value and modulus top, up (1=up, 0=down), sat
// (1=saturate, 0=wrap); nxt next value, carry/borrow wrap indicators,
// hit when a bound was reached in either mode.
module count_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output logic             carry,
  output logic             borrow,
  output logic             hit
);

  always_comb begin
    nxt    = q;
    carry  = 1'b0;
    borrow = 1'b0;
    hit    = 1'b0;
    if (up) begin
      // q >= limit also catches values loaded above the modulus.
      if (q >= limit) begin
        hit = 1'b1;
        if (sat) begin
          nxt = limit;
        end else begin
          nxt   = '0;
          carry = 1'b1;
        end
      end else begin
        nxt = q + WIDTH'(1);
      end
    end else begin
      if (q == '0) begin
        hit = 1'b1;
        if (sat) begin
          nxt = '0;
        end else begin
          nxt    = limit;
          borrow = 1'b1;
        end
      end else begin
        nxt = q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/load_count_reg.sv
// Loadable up/down counter register with programmable modulus, wrap or
// saturate mode, carry/borrow pulses, sticky overflow and a self-timed run.
// Ports: clk, rst (sync, active high), clr, ld/din, inc, dec, limit, sat,
// start, ovf_clr in; q, co, bo, ovf, busy, done registered out; tc
// combinational (q == limit).
module load_count_reg
  import count_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  input  logic             start,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             bo,
  output logic             tc,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  run_state_t       state, state_n;
  cmd_t             cmd;
  logic [WIDTH-1:0] q_n;
  logic             co_n, bo_n, ovf_n;
  logic             running;
  logic [WIDTH-1:0] step_nxt;
  logic             step_carry, step_borrow, step_hit;

  assign running = (state == RUN);
  assign cmd     = decode_cmd(clr, ld, running, inc, dec);

  // A run always counts up; saturation is meaningless inside a run.
  count_step #(.WIDTH(WIDTH)) u_step (
    .q      (q),
    .limit  (limit),
    .up     (running | inc),
    .sat    (sat & ~running),
    .nxt    (step_nxt),
    .carry  (step_carry),
    .borrow (step_borrow),
    .hit    (step_hit)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    q_n     = q;
    co_n    = 1'b0;
    bo_n    = 1'b0;
    ovf_n   = ovf & ~ovf_clr;
    case (cmd)
      CMD_CLR: begin
        q_n     = RESET_VAL;
        ovf_n   = 1'b0;
        state_n = IDLE;
      end
      CMD_LD: begin
        q_n     = din;
        state_n = IDLE;
      end
      CMD_RUN: begin
        // Already at (or above a lowered) limit: finish without counting.
        // Otherwise finish on the same edge that lands on limit.
        if (q >= limit) begin
          state_n = DONE;
        end else begin
          q_n = step_nxt;
          if (step_nxt == limit)
            state_n = DONE;
        end
      end
      CMD_STEP: begin
        q_n  = step_nxt;
        co_n = step_carry;
        bo_n = step_borrow;
        if (step_hit)
          ovf_n = 1'b1;
      end
      default: begin
      end
    endcase
    if (cmd == CMD_STEP || cmd == CMD_HOLD) begin
      if (state == IDLE && start)
        state_n = RUN;
      else if (state == DONE)
        state_n = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= RESET_VAL;
      co    <= 1'b0;
      bo    <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      co    <= co_n;
      bo    <= bo_n;
      ovf   <= ovf_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

  assign tc = (q == limit);

endmodule

// File: tb/tb_load_count_reg.sv
// Directed, table-driven bench for load_count_reg (WIDTH=8, RESET_VAL=0).
module tb_load_count_reg;

  logic       clk, rst, clr, ld, inc, dec, sat, start, ovf_clr;
  logic [7:0] din, limit, q;
  logic       co, bo, tc, ovf, busy, done;

  load_count_reg #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din), .inc(inc),
    .dec(dec), .limit(limit), .sat(sat), .start(start), .ovf_clr(ovf_clr),
    .q(q), .co(co), .bo(bo), .tc(tc), .ovf(ovf), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, clr, ld;
    logic [7:0] din;
    logic       inc, dec;
    logic [7:0] limit;
    logic       sat, start, oc;
    logic [7:0] eq;
    logic       eco, ebo, eovf, ebusy, edone;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input string name, input logic r, input logic c,
                              input logic l, input int d, input logic i,
                              input logic de, input int lim, input logic s,
                              input logic st, input logic oc, input int eq,
                              input logic eco, input logic ebo,
                              input logic eovf, input logic ebusy,
                              input logic edone);
    vec_t v;
    v.name = name; v.rst = r; v.clr = c; v.ld = l; v.din = 8'(d);
    v.inc = i; v.dec = de; v.limit = 8'(lim); v.sat = s; v.start = st;
    v.oc = oc; v.eq = 8'(eq); v.eco = eco; v.ebo = ebo; v.eovf = eovf;
    v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; clr = v.clr; ld = v.ld; din = v.din; inc = v.inc;
    dec = v.dec; limit = v.limit; sat = v.sat; start = v.start;
    ovf_clr = v.oc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input vec_t v);
    logic etc;
    etc = (v.eq == v.limit);
    n_checks++;
    if (q !== v.eq || co !== v.eco || bo !== v.ebo || ovf !== v.eovf ||
        busy !== v.ebusy || done !== v.edone || tc !== etc) begin
      n_fail++;
      $display("FAIL %s: got q=%0d co=%b bo=%b ovf=%b busy=%b done=%b tc=%b, want q=%0d co=%b bo=%b ovf=%b busy=%b done=%b tc=%b",
               v.name, q, co, bo, ovf, busy, done, tc,
               v.eq, v.eco, v.ebo, v.eovf, v.ebusy, v.edone, etc);
    end
  endtask

  task automatic run_vec(input vec_t v);
    apply(v);
    check(v);
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int cycles;
    logic got;
    rst = 1'b0; clr = 1'b0; ld = 1'b0; din = '0; inc = 1'b0; dec = 1'b0;
    limit = '0; sat = 1'b0; start = 1'b0; ovf_clr = 1'b0;

    //               name        rst clr ld din inc dec lim sat st oc   q co bo ovf bsy dn
    vecs.push_back(mk("rst0",     1, 0, 0,  0, 0, 0,  9, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rst1",     1, 0, 0,  0, 0, 0,  9, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld4",      0, 0, 1,  4, 0, 0,  9, 0, 0, 0,   4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("clr_ld",   0, 1, 1, 99, 0, 0,  9, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld8",      0, 0, 1,  8, 0, 0,  9, 0, 0, 0,   8, 0, 0, 0, 0, 0));
    vecs.push_back(mk("up9",      0, 0, 0,  0, 1, 0,  9, 0, 0, 0,   9, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wrap0",    0, 0, 0,  0, 1, 0,  9, 0, 0, 0,   0, 1, 0, 1, 0, 0));
    vecs.push_back(mk("up1",      0, 0, 0,  0, 1, 0,  9, 0, 0, 0,   1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("ovf_hold", 0, 0, 0,  0, 0, 0,  9, 0, 0, 0,   1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("ovf_clr",  0, 0, 0,  0, 0, 0,  9, 0, 0, 1,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld9_sat",  0, 0, 1,  9, 0, 0,  9, 1, 0, 0,   9, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sat_a",    0, 0, 0,  0, 1, 0,  9, 1, 0, 0,   9, 0, 0, 1, 0, 0));
    vecs.push_back(mk("sat_b",    0, 0, 0,  0, 1, 0,  9, 1, 0, 0,   9, 0, 0, 1, 0, 0));
    vecs.push_back(mk("set_wins", 0, 0, 0,  0, 1, 0,  9, 1, 0, 1,   9, 0, 0, 1, 0, 0));
    vecs.push_back(mk("ovf_clr2", 0, 0, 0,  0, 0, 0,  9, 1, 0, 1,   9, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld0",      0, 0, 1,  0, 0, 0,  9, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("dn_wrap",  0, 0, 0,  0, 0, 1,  9, 0, 0, 0,   9, 0, 1, 1, 0, 0));
    vecs.push_back(mk("bo_end",   0, 0, 0,  0, 0, 0,  9, 0, 0, 0,   9, 0, 0, 1, 0, 0));
    vecs.push_back(mk("clr_ovf",  0, 1, 0,  0, 0, 0,  9, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld5",      0, 0, 1,  5, 0, 0,  9, 0, 0, 0,   5, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("incdec", 0, 0, 0,  0, 1, 1,  9, 0, 0, 0,   5, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld200",    0, 0, 1,200, 0, 0, 50, 0, 0, 0, 200, 0, 0, 0, 0, 0));
    vecs.push_back(mk("above_lim",0, 0, 0,  0, 1, 0, 50, 0, 0, 0,   0, 1, 0, 1, 0, 0));
    vecs.push_back(mk("ovf_clr3", 0, 0, 0,  0, 0, 0, 50, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld50",     0, 0, 1, 50, 0, 0, 55, 0, 0, 0,  50, 0, 0, 0, 0, 0));
    vecs.push_back(mk("start",    0, 0, 0,  0, 0, 0, 55, 0, 1, 0,  50, 0, 0, 0, 1, 0));
    vecs.push_back(mk("run51",    0, 0, 0,  0, 0, 0, 55, 0, 0, 0,  51, 0, 0, 0, 1, 0));
    vecs.push_back(mk("run52_st", 0, 0, 0,  0, 0, 0, 55, 0, 1, 0,  52, 0, 0, 0, 1, 0));
    vecs.push_back(mk("run53_dec",0, 0, 0,  0, 0, 1, 55, 0, 0, 0,  53, 0, 0, 0, 1, 0));
    vecs.push_back(mk("run54",    0, 0, 0,  0, 0, 0, 55, 0, 0, 0,  54, 0, 0, 0, 1, 0));
    vecs.push_back(mk("run_done", 0, 0, 0,  0, 0, 0, 55, 0, 0, 0,  55, 0, 0, 0, 0, 1));
    vecs.push_back(mk("run_idle", 0, 0, 0,  0, 0, 0, 55, 0, 0, 0,  55, 0, 0, 0, 0, 0));
    vecs.push_back(mk("st_at_lim",0, 0, 0,  0, 0, 0, 55, 0, 1, 0,  55, 0, 0, 0, 1, 0));
    vecs.push_back(mk("lim_done", 0, 0, 0,  0, 0, 0, 55, 0, 0, 0,  55, 0, 0, 0, 0, 1));
    vecs.push_back(mk("lim_idle", 0, 0, 0,  0, 0, 0, 55, 0, 0, 0,  55, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ld10",     0, 0, 1, 10, 0, 0, 20, 0, 0, 0,  10, 0, 0, 0, 0, 0));
    vecs.push_back(mk("start10",  0, 0, 0,  0, 0, 0, 20, 0, 1, 0,  10, 0, 0, 0, 1, 0));
    vecs.push_back(mk("run11",    0, 0, 0,  0, 0, 0, 20, 0, 0, 0,  11, 0, 0, 0, 1, 0));
    vecs.push_back(mk("lim_drop", 0, 0, 0,  0, 0, 0,  5, 0, 0, 0,  11, 0, 0, 0, 0, 1));
    vecs.push_back(mk("drop_idle",0, 0, 0,  0, 0, 0,  5, 0, 0, 0,  11, 0, 0, 0, 0, 0));

    foreach (vecs[i])
      run_vec(vecs[i]);

    // Abort by load after 10 run cycles.
    run_vec(mk("ab_ld0",   0, 0, 1, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mk("ab_start", 0, 0, 0, 0, 0, 0, 100, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 10; i++)
      run_vec(mk("ab_run", 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, i, 0, 0, 0, 1, 0));
    run_vec(mk("ab_ld7",   0, 0, 1, 7, 0, 0, 100, 0, 0, 0, 7, 0, 0, 0, 0, 0));
    run_vec(mk("ab_after", 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 7, 0, 0, 0, 0, 0));

    // Run from 7 to 12: done expected on the 5th edge after the start edge.
    run_vec(mk("t_start",  0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 7, 0, 0, 0, 1, 0));
    cycles = 0;
    got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      apply(mk("t_wait", 0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      cycles++;
      if (done === 1'b1)
        got = 1'b1;
    end
    cmp_int("run_done_seen", int'(got), 1);
    cmp_int("run_len", cycles, 5);
    cmp_int("run_end_q", int'(q), 12);
    run_vec(mk("t_idle",   0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 12, 0, 0, 0, 0, 0));

    // Abort by reset mid-run.
    run_vec(mk("rs_start", 0, 0, 0, 0, 0, 0, 100, 0, 1, 0, 12, 0, 0, 0, 1, 0));
    run_vec(mk("rs_run13", 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 13, 0, 0, 0, 1, 0));
    run_vec(mk("rs_run14", 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 14, 0, 0, 0, 1, 0));
    run_vec(mk("rs_rst",   1, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mk("rs_after", 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
